// File: rtl/taylor_arbiter.sv
// Round-robin arbiter sharing a single cosine core among N_REQ requesters.
// Optional core watchdog: define TAYLOR_ARB_TIMEOUT_EN to add the ABORT state and err_o.
module taylor_arbiter #(
  parameter int unsigned W       = 18,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*W-1:0]       angle_i,
  output logic [N_REQ-1:0]         done_o,
  output logic [W-1:0]             result_o,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     busy_o,
  output logic                     core_start_o,
  output logic [W-1:0]             core_angle_o,
  input  logic                     core_ready_i,
  input  logic [W-1:0]             core_result_i,
  output logic                     core_rst_o
`ifdef TAYLOR_ARB_TIMEOUT_EN
  ,
  output logic                     err_o
`endif
);

  localparam int unsigned GW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    RELEASE = 3'd3
`ifdef TAYLOR_ARB_TIMEOUT_EN
    ,
    ABORT   = 3'd4
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_q, last_d;
  logic [W-1:0]     angle_q, angle_d;
  logic [W-1:0]     result_q, result_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             core_rst_q, core_rst_d;
  logic             ready_q;
  logic             ready_rise;
  logic             win_valid;
  logic [GW-1:0]    win_idx;
  logic [GW-1:0]    cand;
  logic [W-1:0]     angle_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_angle
    assign angle_arr[i] = angle_i[i*W +: W];
  end

  // Only a fresh 0->1 transition counts; a level left high by the previous job is ignored.
  assign ready_rise = core_ready_i & ~ready_q;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = GW'((32'(last_q) + k) % N_REQ);
      if (!win_valid && req_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef TAYLOR_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    angle_d    = angle_q;
    result_d   = result_q;
    done_d     = '0;
    start_d    = 1'b0;
    core_rst_d = 1'b0;
`ifdef TAYLOR_ARB_TIMEOUT_EN
    cnt_d      = '0;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d = win_idx;
          angle_d = angle_arr[win_idx];
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (ready_rise) begin
          result_d        = core_result_i;
          last_d          = grant_q;
          done_d[grant_q] = 1'b1;
          start_d         = 1'b1;
          state_d         = RELEASE;
        end
`ifdef TAYLOR_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          result_d        = '0;
          last_d          = grant_q;
          done_d[grant_q] = 1'b1;
          core_rst_d      = 1'b1;
          err_d           = 1'b1;
          state_d         = ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        state_d = IDLE;
      end
`ifdef TAYLOR_ARB_TIMEOUT_EN
      ABORT: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= GW'(N_REQ - 1);
      angle_q    <= '0;
      result_q   <= '0;
      done_q     <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      angle_q    <= angle_d;
      result_q   <= result_d;
      done_q     <= done_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      core_rst_q <= core_rst_d;
      ready_q    <= core_ready_i;
    end
  end

`ifdef TAYLOR_ARB_TIMEOUT_EN
  // Watchdog counter and error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

  assign done_o       = done_q;
  assign result_o     = result_q;
  assign grant_id_o   = grant_q;
  assign busy_o       = busy_q;
  assign core_start_o = start_q;
  assign core_angle_o = angle_q;
  assign core_rst_o   = core_rst_q;

endmodule

// File: tb/tb_taylor_arbiter.sv
// Self-checking bench for taylor_arbiter with a behavioural cosine-core responder.
module tb_taylor_arbiter;
  localparam int unsigned W   = 18;
  localparam int unsigned NR  = 4;
  localparam int unsigned TO  = 32;
  localparam int          LAT = 7;
  localparam logic [W-1:0] GARB = 18'h15555;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] angle;
  logic [NR-1:0]   done;
  logic [W-1:0]    result;
  logic [1:0]      grant_id;
  logic            busy;
  logic            core_start;
  logic [W-1:0]    core_angle;
  logic            core_ready;
  logic [W-1:0]    core_result;
  logic            core_rst;
`ifdef TAYLOR_ARB_TIMEOUT_EN
  logic            err;
`endif

  int total, bad, cyc;
  bit core_busy, stale_mode, dead;
  int cnt, clr_dly, rise_cyc;
  logic [W-1:0] res_val;

  taylor_arbiter #(.W(W), .N_REQ(NR), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .angle_i      (angle),
    .done_o       (done),
    .result_o     (result),
    .grant_id_o   (grant_id),
    .busy_o       (busy),
    .core_start_o (core_start),
    .core_angle_o (core_angle),
    .core_ready_i (core_ready),
    .core_result_i(core_result),
    .core_rst_o   (core_rst)
`ifdef TAYLOR_ARB_TIMEOUT_EN
    ,
    .err_o        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q16 cosine reference, used both by the core responder and by the expectations.
  function automatic logic [W-1:0] cos_q16(input logic [W-1:0] a);
    real x;
    x = real'(a) / 65536.0;
    return W'($rtoi($cos(x) * 65536.0 + 0.5));
  endfunction

  // One clock: advance to the falling edge, then update the core responder.
  task automatic tick();
    logic prev;
    @(negedge clk);
    cyc++;
    prev = core_ready;
    if (core_rst) begin
      core_busy = 0; cnt = 0; clr_dly = 0;
      core_ready = 1'b0; core_result = GARB;
    end else if (core_start) begin
      if (!core_busy) begin
        core_busy = 1; cnt = LAT; res_val = cos_q16(core_angle);
        if (stale_mode && core_ready) clr_dly = 3;
        else begin core_ready = 1'b0; core_result = GARB; end
      end else begin
        core_busy = 0;
        if (!stale_mode) begin core_ready = 1'b0; core_result = GARB; end
      end
    end else begin
      if (clr_dly > 0) begin
        clr_dly--;
        if (clr_dly == 0) begin core_ready = 1'b0; core_result = GARB; end
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !dead) begin core_ready = 1'b1; core_result = res_val; end
      end
    end
    if (core_ready && !prev) rise_cyc = cyc;
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done !== '0) begin at = cyc; break; end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; angle = '0; stale_mode = 0; dead = 0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++;
    if (done !== '0 || result !== '0 || busy !== 1'b0 || core_start !== 1'b0 ||
        grant_id !== '0 || core_angle !== '0 || core_rst !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: done=%b result=%h busy=%b start=%b grant=%0d angle=%h core_rst=%b required 0,0,0,0,0,0,1",
               done, result, busy, core_start, grant_id, core_angle, core_rst);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (core_rst !== 1'b0 || busy !== 1'b0 || done !== '0) begin
      bad++;
      $display("FAIL reset_release: core_rst=%b busy=%b done=%b required 0,0,0", core_rst, busy, done);
    end
  endtask

  task automatic test_single();
    bit exp_start;
    do_reset();
    tick();
    req = 4'b0001;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_start = (i == 1 || i == 9);
      total++;
      if (core_start !== exp_start) begin
        bad++;
        $display("FAIL single_core_start c%0d: got %b required %b", i, core_start, exp_start);
      end
      total++;
      if (done !== ((i == 9) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL single_done c%0d: got %b required %b", i, done, (i == 9) ? 4'b0001 : 4'b0000);
      end
      total++;
      if (busy !== (i <= 9)) begin
        bad++;
        $display("FAIL single_busy c%0d: got %b required %b", i, busy, (i <= 9));
      end
      if (i == 9) begin
        total++;
        if (result !== 18'h10000) begin
          bad++;
          $display("FAIL single_result: got %h required 10000", result);
        end
        req = '0;
      end
    end
  endtask

  task automatic test_round_robin();
    int c0, at, exp;
    logic [W-1:0] ang [NR];
    ang[0] = 18'h01000; ang[1] = 18'h04000; ang[2] = 18'h08000; ang[3] = 18'h0C000;
    do_reset();
    tick();
    c0 = cyc;
    for (int i = 0; i < NR; i++) angle[i*W +: W] = ang[i];
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp = j % NR;
      wait_done(20, at);
      total++;
      if (at != c0 + 9 + 10 * j || done !== 4'(1 << exp)) begin
        bad++;
        $display("FAIL rr_order job%0d: done=%b at c%0d required %b at c%0d", j, done, at - c0, 4'(1 << exp), 9 + 10 * j);
      end
      total++;
      if (result !== cos_q16(ang[exp])) begin
        bad++;
        $display("FAIL rr_result job%0d: got %h required %h", j, result, cos_q16(ang[exp]));
      end
      if (at < 0) break;
    end
    req = '0;
    tick(); tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rr_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_stale_ready();
    int c0, at, d;
    do_reset();
    stale_mode = 1;
    tick();
    c0 = cyc;
    angle[0 +: W] = 18'h03000;
    req = 4'b0001;
    wait_done(15, at);
    total++;
    if (at != c0 + 9 || done !== 4'b0001) begin
      bad++;
      $display("FAIL stale_first: done=%b at c%0d required 0001 at c9", done, at - c0);
    end
    d = at;
    req = 4'b0010;
    angle[W +: W] = 18'h05000;
    wait_done(25, at);
    total++;
    if (done !== 4'b0010 || at != rise_cyc + 1 || rise_cyc <= d) begin
      bad++;
      $display("FAIL stale_edge: done=%b at c%0d, ready rise c%0d, previous done c%0d; required 0010 one cycle after a new rise",
               done, at, rise_cyc, d);
    end
    total++;
    if (result !== cos_q16(18'h05000)) begin
      bad++;
      $display("FAIL stale_result: got %h required %h", result, cos_q16(18'h05000));
    end
    req = '0;
    stale_mode = 0;
  endtask

  task automatic test_drop();
    do_reset();
    tick();
    angle[2*W +: W] = 18'h0A000;
    req = 4'b0100;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) begin
        total++;
        if (grant_id !== 2'd2 || busy !== 1'b1) begin
          bad++;
          $display("FAIL drop_grant: grant=%0d busy=%b required 2,1", grant_id, busy);
        end
      end
      if (i == 3) req = '0;
      total++;
      if (done !== ((i == 9) ? 4'b0100 : 4'b0000)) begin
        bad++;
        $display("FAIL drop_done c%0d: got %b required %b", i, done, (i == 9) ? 4'b0100 : 4'b0000);
      end
      if (i == 9) begin
        total++;
        if (result !== cos_q16(18'h0A000)) begin
          bad++;
          $display("FAIL drop_result: got %h required %h", result, cos_q16(18'h0A000));
        end
      end
      if (i == 10) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL drop_idle: busy=%b required 0", busy);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    angle[0 +: W] = 18'h02000;
    req = 4'b0001;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (done !== '0 || core_rst !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async: done=%b core_rst=%b busy=%b required 0000,1,0", done, core_rst, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (done !== '0) begin
        bad++;
        $display("FAIL midreset_nodone %0d: done=%b required 0000", i, done);
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++;
      if (done !== ((i == 9) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL midreset_rerun c%0d: done=%b required %b", i, done, (i == 9) ? 4'b0001 : 4'b0000);
      end
    end
    total++;
    if (result !== cos_q16(18'h02000)) begin
      bad++;
      $display("FAIL midreset_result: got %h required %h", result, cos_q16(18'h02000));
    end
    req = '0;
  endtask

  task automatic test_random();
    int last, exp, d, r, exp_cyc, at;
    logic [NR-1:0] reqv;
    logic [W-1:0] ang [NR];
    do_reset();
    last = NR - 1;
    d = -100;
    tick();
    r = cyc;
    reqv = 4'($urandom_range(1, 15));
    for (int i = 0; i < NR; i++) begin
      ang[i] = W'($urandom_range(0, 98304));
      angle[i*W +: W] = ang[i];
    end
    req = reqv;
    for (int j = 0; j < 40; j++) begin
      exp = -1;
      for (int k = 1; k <= NR; k++)
        if (exp < 0 && reqv[(last + k) % NR]) exp = (last + k) % NR;
      exp_cyc = ((d + 1 > r) ? d + 1 : r) + 9;
      wait_done(exp_cyc - cyc + 3, at);
      total++;
      if (at != exp_cyc || done !== 4'(1 << exp) || grant_id !== 2'(exp)) begin
        bad++;
        $display("FAIL rand_job%0d: done=%b grant=%0d at c%0d required %b grant %0d at c%0d",
                 j, done, grant_id, at, 4'(1 << exp), exp, exp_cyc);
      end
      total++;
      if (result !== cos_q16(ang[exp])) begin
        bad++;
        $display("FAIL rand_result%0d: got %h required %h", j, result, cos_q16(ang[exp]));
      end
      if (at < 0) break;
      last = exp;
      d = at;
      reqv[exp] = 1'b0;
      for (int i = 0; i < NR; i++)
        if (i != exp && !reqv[i] && $urandom_range(0, 2) == 0) begin
          reqv[i] = 1'b1;
          ang[i] = W'($urandom_range(0, 98304));
        end
      if (reqv == '0) begin
        req = '0;
        repeat ($urandom_range(1, 4)) tick();
        reqv = 4'($urandom_range(1, 15));
        for (int i = 0; i < NR; i++)
          if (reqv[i]) ang[i] = W'($urandom_range(0, 98304));
      end
      r = cyc;
      for (int i = 0; i < NR; i++) angle[i*W +: W] = ang[i];
      req = reqv;
    end
    req = '0;
  endtask

`ifdef TAYLOR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int c0, at;
    do_reset();
    dead = 1;
    tick();
    c0 = cyc;
    req = 4'b0100;
    wait_done(TO + 10, at);
    total++;
    if (at != c0 + 2 + int'(TO) || done !== 4'b0100 || err !== 1'b1 || result !== '0 || core_rst !== 1'b1) begin
      bad++;
      $display("FAIL timeout_abort: at c%0d done=%b err=%b result=%h core_rst=%b required c%0d 0100,1,0,1",
               at - c0, done, err, result, core_rst, 2 + TO);
    end
    dead = 0;
    angle[3*W +: W] = 18'h06000;
    req = 4'b1001;
    tick(); tick();
    total++;
    if (grant_id !== 2'd3 || core_start !== 1'b1) begin
      bad++;
      $display("FAIL timeout_next: grant=%0d start=%b required 3,1", grant_id, core_start);
    end
    wait_done(12, at);
    total++;
    if (done !== 4'b1000 || result !== cos_q16(18'h06000) || err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_recover: done=%b result=%h err=%b required 1000,%h,0", done, result, err, cos_q16(18'h06000));
    end
    req = '0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; req = '0; angle = '0;
    core_ready = 1'b0; core_result = GARB;
    core_busy = 0; stale_mode = 0; dead = 0;
    cnt = 0; clr_dly = 0; rise_cyc = -1; res_val = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stale_ready();
    test_drop();
    test_reset_mid();
    test_random();
`ifdef TAYLOR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/taylor_arbiter.md
TAYLOR_ARBITER -- requirements
Module: taylor_arbiter

Interface
REQ-001 Parameter W, default 18, shall set the angle/result width (Q16 fixed point, matches the cosine core).
REQ-002 Parameter N_REQ, default 4, shall set the number of requesters (2..8).
REQ-003 Parameter TIMEOUT, default 32, shall set the core watchdog limit in cycles (used only with REQ-028).
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req  in  N_REQ  per-requester level request; held high until the matching done pulse.
REQ-007 angle_in  in  N_REQ*W  flattened angles; slice i = angle_in[i*W +: W]; stable while req[i] is high.
REQ-008 done  out  N_REQ  one-hot, one-cycle completion pulse.
REQ-009 result  out  W  cosine result, valid only in the done cycle.
REQ-010 grant_id  out  clog2(N_REQ)  index of the requester currently being served.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 core_start  out  1  start strobe to the cosine core.
REQ-013 core_angle  out  W  angle to the core; held from START until result capture.
REQ-014 core_ready  in  1  core completion flag; sticky, cleared by the core internally after a start.
REQ-015 core_result  in  W  core result.
REQ-016 core_rst  out  1  active-high synchronous reset for the core.

Function
REQ-017 States shall be IDLE, START, WAIT and RELEASE, plus ABORT when REQ-028 is enabled.
REQ-018 IDLE: if any req bit is high, pick a winner round-robin starting at last_grant+1 (wrapping at N_REQ-1 to 0), latch grant_id and core_angle, then go to START; otherwise stay in IDLE.
REQ-019 START: core_start=1 for exactly one cycle; next state WAIT.
REQ-020 Completion shall be a rising edge of core_ready (core_ready=1 and registered previous value=0); a stale high level left over from the previous job shall never count as completion.
REQ-021 WAIT: on completion, register core_result into result, set last_grant=grant_id, then go to RELEASE.
REQ-022 RELEASE: done[grant_id]=1 for one cycle, result valid, core_start=1 for one cycle (returns the core to idle); next state IDLE.
REQ-023 Latency: req[i] high in cycle c0 with the arbiter idle gives done[i] in cycle c9; sustained throughput shall be one job per 10 cycles.
REQ-024 If req[i] drops while granted, the job shall still complete and done[i] shall still pulse.
REQ-025 Only req changes shall be sampled in IDLE; no preemption.
REQ-026 done shall be all-zero outside RELEASE/ABORT; at most one done bit high per cycle.

Reset
REQ-027 While reset=0: state=IDLE, last_grant=N_REQ-1 (requester 0 wins first), grant_id=0, core_start=0, core_angle=0, done=0, result=0, busy=0, core_rst=1, ready-edge register=0; core_rst shall deassert on the first clock edge after reset release. Reset mid-job shall discard the job with no done pulse.

Configuration
REQ-028 With TAYLOR_ARB_TIMEOUT_EN defined: a cycle counter runs in WAIT; if it reaches TIMEOUT-1 without completion, go to ABORT: core_rst=1, done[grant_id]=1, result=0 and output err=1, all for one cycle, last_grant=grant_id; then IDLE.
REQ-029 Without TAYLOR_ARB_TIMEOUT_EN: no counter, no ABORT state, no err port; WAIT shall be held indefinitely.

Verification
REQ-030 Reset release, req=0001, angle0=0 -> done=0001 in c9, result=18'h10000, core_start high in exactly c1 and c9.
REQ-031 req=1111 held with distinct angles -> done order 0,1,2,3,0; done pulses 10 cycles apart.
REQ-032 After a job for req0 (core_ready left high), req=0010 -> no early done; done[1] only after a fresh core_ready rising edge.
REQ-033 req2 dropped 3 cycles after grant -> done[2] still pulses in c9; arbiter returns to IDLE.
REQ-034 reset pulled low in WAIT -> done stays 0000, core_rst=1, busy=0 immediately; a new req=0001 after release completes normally.
REQ-035 TAYLOR_ARB_TIMEOUT_EN defined, core_ready tied 0, req=0100 -> err=1, done=0100, result=0 after TIMEOUT cycles in WAIT; next grant goes to requester 3.
